// File: rtl/conmutador_nxn_pkg.sv
// rtl/conmutador_nxn_pkg.sv - shared defaults, width helper and reset constants for conmutador_nxn
package conmutador_nxn_pkg;

   localparam int N_DEF      = 4;
   localparam int DATA_W_DEF = 10;
   localparam int DEPTH_DEF  = 8;
   localparam int CNT_W_DEF  = 5;

   // Default almost-full / almost-empty thresholds for the output FIFOs.
   localparam int ALTO_DEF   = 6;
   localparam int BAJO_DEF   = 1;

   localparam int CNT_RST    = 0;
   localparam int PTR_RST    = 0;

   // Never returns 0 so derived widths always give a legal vector.
   function automatic int log2_ceil(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/conmutador_nxn_fifo_sa.sv
// rtl/conmutador_nxn_fifo_sa.sv - show-ahead FIFO with thresholds and a sticky overflow flag
module conmutador_nxn_fifo_sa
   import conmutador_nxn_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  DEPTH  = DEPTH_DEF,
   localparam int PTR_W  = log2_ceil(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   input  logic [PTR_W:0]    alto,
   input  logic [PTR_W:0]    bajo,
   output logic [DATA_W-1:0] data_out,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic [DATA_W-1:0] last_q;
   logic              full;
   logic              do_push;
   logic              do_pop;

   assign empty        = (count == '0);
   assign full         = (count == (PTR_W+1)'(DEPTH));
   assign almost_full  = full || (count >= alto);
   assign almost_empty = (count <= bajo);
   assign do_push      = push && !full;
   assign do_pop       = pop && !empty;

   // When empty the last popped word stays visible instead of stale storage.
   assign data_out = empty ? last_q : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= PTR_W'(PTR_RST);
         rd_ptr   <= PTR_W'(PTR_RST);
         count    <= '0;
         last_q   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            last_q <= mem[rd_ptr];
         end
         if (push && full) overflow <= 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/conmutador_nxn.sv
// rtl/conmutador_nxn.sv - N-port word switch: input FIFOs, round-robin arbiter, output FIFOs, counters
module conmutador_nxn
   import conmutador_nxn_pkg::*;
#(
   parameter int  N      = N_DEF,
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  DEPTH  = DEPTH_DEF,
   parameter int  CNT_W  = CNT_W_DEF,
   localparam int DEST_W = log2_ceil(N),
   localparam int PTR_W  = log2_ceil(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PTR_W:0]      alto,
   input  logic [PTR_W:0]      bajo,
   input  logic [N-1:0]        push,
   input  logic [N*DATA_W-1:0] data_in,
   input  logic [N-1:0]        pop,
   output logic [N*DATA_W-1:0] data_out,
   output logic [2*N-1:0]      empty_fifos,
   output logic [N-1:0]        almost_empty_out,
   output logic [N-1:0]        overflow_err,
   output logic                idle,
   input  logic [DEST_W-1:0]   idx,
   input  logic                req,
   output logic                valid_contador,
   output logic [CNT_W-1:0]    contador_out
);

   logic [DATA_W-1:0] in_head [N];
   logic [DEST_W-1:0] in_dest [N];
   logic [N-1:0]      in_empty;
   logic [N-1:0]      in_pop;
   logic [N-1:0]      out_empty;
   logic [N-1:0]      out_af;
   logic [N-1:0]      out_push;
   logic [N-1:0]      elig;
   logic [N-1:0]      in_af_unused;
   logic [N-1:0]      in_ae_unused;
   logic [N-1:0]      out_ovf_unused;

   logic [DEST_W-1:0] rr_q;
   logic [DEST_W-1:0] grant;
   logic              grant_valid;
   logic [DATA_W-1:0] xfer_word;
   logic [DEST_W-1:0] xfer_dest;
   logic [CNT_W-1:0]  cnt_q [N];
   logic              idle_q;

   for (genvar i = 0; i < N; i++) begin : g_in
      conmutador_nxn_fifo_sa #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk          (clk),
         .reset        (reset),
         .push         (push[i]),
         .pop          (in_pop[i]),
         .data_in      (data_in[i*DATA_W +: DATA_W]),
         .alto         (alto),
         .bajo         (bajo),
         .data_out     (in_head[i]),
         .empty        (in_empty[i]),
         .almost_full  (in_af_unused[i]),
         .almost_empty (in_ae_unused[i]),
         .overflow     (overflow_err[i])
      );

      assign in_dest[i] = in_head[i][DATA_W-1 -: DEST_W];
      // A head word only competes when its destination can still absorb it.
      assign elig[i]    = !in_empty[i] && !out_af[in_dest[i]];
   end

   for (genvar j = 0; j < N; j++) begin : g_out
      conmutador_nxn_fifo_sa #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk          (clk),
         .reset        (reset),
         .push         (out_push[j]),
         .pop          (pop[j]),
         .data_in      (xfer_word),
         .alto         (alto),
         .bajo         (bajo),
         .data_out     (data_out[j*DATA_W +: DATA_W]),
         .empty        (out_empty[j]),
         .almost_full  (out_af[j]),
         .almost_empty (almost_empty_out[j]),
         .overflow     (out_ovf_unused[j])
      );
   end

   // First eligible input at or after the rr pointer; the index wraps in DEST_W bits.
   always_comb begin
      grant       = rr_q;
      grant_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!grant_valid && elig[rr_q + DEST_W'(k)]) begin
            grant       = rr_q + DEST_W'(k);
            grant_valid = 1'b1;
         end
      end
   end

   assign xfer_word = in_head[grant];
   assign xfer_dest = in_dest[grant];
   assign in_pop    = grant_valid ? (N'(1) << grant)     : '0;
   assign out_push  = grant_valid ? (N'(1) << xfer_dest) : '0;

   assign empty_fifos = {out_empty, in_empty};
   assign idle        = idle_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q           <= DEST_W'(PTR_RST);
         idle_q         <= 1'b1;
         valid_contador <= 1'b0;
         contador_out   <= CNT_W'(CNT_RST);
         for (int j = 0; j < N; j++) cnt_q[j] <= CNT_W'(CNT_RST);
      end else begin
         if (grant_valid) rr_q <= grant + DEST_W'(1);
         idle_q <= (&in_empty) && (&out_empty) && !grant_valid;
         for (int j = 0; j < N; j++) begin
            if (pop[j] && !out_empty[j]) cnt_q[j] <= cnt_q[j] + CNT_W'(1);
         end
         // Reads only complete while quiescent; the value predates this edge's pops.
         if (req && idle_q) begin
            valid_contador <= 1'b1;
            contador_out   <= cnt_q[idx];
         end else begin
            valid_contador <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conmutador_nxn.sv
// tb/tb_conmutador_nxn.sv - scoreboard bench for conmutador_nxn with directed vectors
module tb_conmutador_nxn;

   localparam int N  = 4;
   localparam int DW = 10;
   localparam int CW = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic [3:0]      alto;
   logic [3:0]      bajo;
   logic [N-1:0]    push;
   logic [N*DW-1:0] data_in;
   logic [N-1:0]    pop;
   logic [N*DW-1:0] data_out;
   logic [2*N-1:0]  empty_fifos;
   logic [N-1:0]    almost_empty_out;
   logic [N-1:0]    overflow_err;
   logic            idle;
   logic [1:0]      idx;
   logic            req;
   logic            valid_contador;
   logic [CW-1:0]   contador_out;

   int              total = 0;
   int              bad   = 0;
   logic [DW-1:0]   exp_q [N][$];
   logic [DW-1:0]   mon_exp;

   conmutador_nxn #(
      .N      (N),
      .DATA_W (DW),
      .DEPTH  (8),
      .CNT_W  (CW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .alto             (alto),
      .bajo             (bajo),
      .push             (push),
      .data_in          (data_in),
      .pop              (pop),
      .data_out         (data_out),
      .empty_fifos      (empty_fifos),
      .almost_empty_out (almost_empty_out),
      .overflow_err     (overflow_err),
      .idle             (idle),
      .idx              (idx),
      .req              (req),
      .valid_contador   (valid_contador),
      .contador_out     (contador_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_queues();
      for (int j = 0; j < N; j++) exp_q[j].delete();
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      push    = '0;
      pop     = '0;
      req     = 1'b0;
      idx     = '0;
      data_in = '0;
      clear_queues();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // One word per cycle into input i; every word is expected at its dest output in order.
   task automatic burst(input int i, input logic [1:0] dest, input logic [7:0] base, input int n);
      push[i] = 1'b1;
      for (int k = 0; k < n; k++) begin
         data_in[i*DW +: DW] = {dest, base + 8'(k)};
         exp_q[dest].push_back({dest, base + 8'(k)});
         tick();
      end
      push[i] = 1'b0;
   endtask

   task automatic drain(input int j);
      int n = 0;
      pop[j] = 1'b1;
      while (exp_q[j].size() != 0 && n < 200) begin
         tick();
         n++;
      end
      pop[j] = 1'b0;
      check($sformatf("drain_out%0d", j), 64'(exp_q[j].size()), 64'd0);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!idle && n < 100) begin
         tick();
         n++;
      end
      check(name, 64'(idle), 64'd1);
   endtask

   task automatic read_counter(input logic [1:0] sel);
      idx = sel;
      req = 1'b1;
      tick();
      req = 1'b0;
   endtask

   // Scoreboard monitor: every effective consumer pop must match the queued expectation.
   always @(negedge clk) begin
      if (!reset) begin
         for (int j = 0; j < N; j++) begin
            if (pop[j] && !empty_fifos[N+j]) begin
               if (exp_q[j].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_word_out%0d actual=%0h required=none", j, data_out[j*DW +: DW]);
               end else begin
                  mon_exp = exp_q[j].pop_front();
                  check($sformatf("word_out%0d", j), 64'(data_out[j*DW +: DW]), 64'(mon_exp));
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      alto = 4'd6;
      bajo = 4'd1;
      do_reset();

      // Reset values, then the two-cycle path of one word.
      check("rst_empty",     64'(empty_fifos),      64'hFF);
      check("rst_idle",      64'(idle),             64'd1);
      check("rst_data_out",  64'(data_out),         64'd0);
      check("rst_aempty",    64'(almost_empty_out), 64'hF);
      check("rst_overflow",  64'(overflow_err),     64'd0);
      check("rst_valid",     64'(valid_contador),   64'd0);
      check("rst_contador",  64'(contador_out),     64'd0);
      push[0] = 1'b1;
      data_in[0 +: DW] = 10'h2A5;
      tick();
      push[0] = 1'b0;
      check("lat_in0_full",   64'(empty_fifos[0]), 64'd0);
      check("lat_out2_empty", 64'(empty_fifos[6]), 64'd1);
      tick();
      check("lat_out2_ready", 64'(empty_fifos[6]), 64'd0);
      check("lat_out2_word",  64'(data_out[2*DW +: DW]), 64'h2A5);
      check("lat_in0_empty",  64'(empty_fifos[0]), 64'd1);
      exp_q[2].push_back(10'h2A5);
      drain(2);
      wait_idle("idle_after_first");

      // Fairness: simultaneous loads; grants 0,1,2,3,... fix the arrival order at each output.
      do_reset();
      for (int w = 0; w < 3; w++) begin
         push = 4'hF;
         for (int i = 0; i < N; i++) begin
            data_in[i*DW +: DW] = {2'((i + w) % 4), 4'(i), 4'(w)};
         end
         tick();
      end
      push = '0;
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < N; i++) begin
            exp_q[(i + w) % 4].push_back({2'((i + w) % 4), 4'(i), 4'(w)});
         end
      end
      begin
         int n = 0;
         while (empty_fifos[3:0] != 4'hF && n < 50) begin
            tick();
            n++;
         end
      end
      check("fair_inputs_drained", 64'(empty_fifos), 64'h0F);
      for (int j = 0; j < N; j++) drain(j);

      // Backpressure: output 1 at the threshold blocks dest 1 only.
      do_reset();
      burst(0, 2'd1, 8'h00, 7);
      repeat (4) tick();
      check("bp_in0_held",  64'(empty_fifos[0]), 64'd0);
      check("bp_out1_aemp", 64'(almost_empty_out[1]), 64'd0);
      burst(1, 2'd2, 8'h55, 1);
      tick();
      check("bp_other_flows", 64'(empty_fifos[6]), 64'd0);
      check("bp_in0_still",   64'(empty_fifos[0]), 64'd0);
      pop[1] = 1'b1;
      tick();
      pop[1] = 1'b0;
      check("bp_in0_pre_resume", 64'(empty_fifos[0]), 64'd0);
      tick();
      check("bp_resume", 64'(empty_fifos[0]), 64'd1);
      drain(1);
      drain(2);

      // Overflow: dest 3 held almost full while input 3 receives nine words.
      do_reset();
      burst(3, 2'd3, 8'h10, 6);
      repeat (3) tick();
      check("ovf_in3_moved", 64'(empty_fifos[3]), 64'd1);
      check("ovf_none_yet",  64'(overflow_err),   64'd0);
      burst(3, 2'd3, 8'h20, 8);
      push[3] = 1'b1;
      data_in[3*DW +: DW] = 10'h3EE;
      tick();
      push[3] = 1'b0;
      check("ovf_set", 64'(overflow_err), 64'h8);
      drain(3);
      repeat (3) tick();
      check("ovf_all_empty", 64'(empty_fifos),  64'hFF);
      check("ovf_sticky",    64'(overflow_err), 64'h8);

      // Counter read: five pops from output 0.
      do_reset();
      burst(2, 2'd0, 8'h40, 5);
      repeat (2) tick();
      drain(0);
      wait_idle("cnt_idle");
      read_counter(2'd1);
      check("cnt1_valid", 64'(valid_contador), 64'd1);
      check("cnt1_value", 64'(contador_out),   64'd0);
      read_counter(2'd0);
      check("cnt0_valid", 64'(valid_contador), 64'd1);
      check("cnt0_value", 64'(contador_out),   64'd5);
      tick();
      check("cnt_valid_drop", 64'(valid_contador), 64'd0);
      burst(0, 2'd1, 8'h66, 1);
      tick();
      check("cnt_busy", 64'(idle), 64'd0);
      read_counter(2'd0);
      check("cnt_busy_valid", 64'(valid_contador), 64'd0);
      check("cnt_busy_hold",  64'(contador_out),   64'd5);
      drain(1);

      // Asynchronous reset in the middle of traffic.
      do_reset();
      burst(1, 2'd0, 8'h77, 1);
      repeat (2) tick();
      drain(0);
      wait_idle("mid_idle");
      read_counter(2'd0);
      check("mid_cnt_before", 64'(contador_out), 64'd1);
      push = 4'hF;
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < N; i++) data_in[i*DW +: DW] = {2'(i), 4'(w), 4'hA};
         tick();
      end
      push = '0;
      #2;
      reset = 1'b1;
      #1;
      check("mid_empty",    64'(empty_fifos),      64'hFF);
      check("mid_data_out", 64'(data_out),         64'd0);
      check("mid_aempty",   64'(almost_empty_out), 64'hF);
      check("mid_idle_rst", 64'(idle),             64'd1);
      check("mid_contador", 64'(contador_out),     64'd0);
      clear_queues();
      tick();
      reset = 1'b0;
      repeat (2) tick();
      check("mid_still_empty", 64'(empty_fifos), 64'hFF);
      read_counter(2'd0);
      check("mid_cnt_valid", 64'(valid_contador), 64'd1);
      check("mid_cnt_zero",  64'(contador_out),   64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conmutador_nxn.md
Name: conmutador_nxn

Overview:
- Parametrised N-port word switch: successor to the fixed 4-channel FIFO/mux/demux/arbiter interconnect.
- Each of N input FIFOs is drained by a round-robin arbiter with output backpressure.
- Each word is routed by its top log2(N) bits into one of N output FIFOs.
- Adds per-output delivered-word counters, programmable watermarks, overflow error flags and an idle indicator; sits between the packet sources and the consumer-side state machine.

Parameters:
- N, 4, number of input and output channels; power of two, 2..8.
- DATA_W, 10, word width; destination field is bits [DATA_W-1 -: DEST_W].
- DEPTH, 8, entries per FIFO; power of two.
- DEST_W, log2(N), destination field width (localparam).
- PTR_W, log2(DEPTH), pointer width (localparam).
- CNT_W, 5, delivered-word counter width.

Ports:
- clk, in, 1, single clock; all state changes on rising edge.
- reset, in, 1, asynchronous, active-high; clears all state.
- alto, in, PTR_W+1, almost-full threshold for output FIFOs.
- bajo, in, PTR_W+1, almost-empty threshold for output FIFOs.
- push, in, N, per-input write strobe.
- data_in, in, N*DATA_W, input words; channel i occupies [i*DATA_W +: DATA_W].
- pop, in, N, per-output read strobe.
- data_out, out, N*DATA_W, output FIFO head words (show-ahead).
- empty_fifos, out, 2*N, bits [N-1:0] = input FIFOs empty, bits [2N-1:N] = output FIFOs empty.
- almost_empty_out, out, N, output FIFO count <= bajo.
- overflow_err, out, N, sticky; a push was attempted into a full input FIFO.
- idle, out, 1, all 2N FIFOs empty and no transfer in flight.
- idx, in, DEST_W, counter select.
- req, in, 1, counter read request.
- valid_contador, out, 1, counter read result valid.
- contador_out, out, CNT_W, selected counter value.

Behaviour:
- Reset:
  - All FIFOs empty; pointers 0.
  - data_out = 0, empty_fifos = all ones, almost_empty_out = all ones, overflow_err = 0.
  - idle = 1, valid_contador = 0, contador_out = 0.
  - Round-robin pointer = 0; all counters = 0.
  - Reset asserted mid-transfer aborts it; no partial writes survive.
- FIFOs:
  - Show-ahead: the head word is visible combinationally when not empty.
  - Push while full: word dropped, overflow_err[i] set until reset.
  - Push and pop on the same cycle while not full/empty: count unchanged.
  - Pop while empty: ignored; data_out holds its last value.
  - Pointers wrap modulo DEPTH; count is PTR_W+1 bits wide to distinguish full from empty.
- Eligibility and arbitration:
  - Input i is eligible when it is not empty and the output FIFO addressed by its head's dest field has almost_full = 0.
  - almost_full is true when count >= alto, or when the FIFO is full regardless of alto.
  - The grant is combinational: the first eligible input at or after the rr pointer, wrapping.
  - On grant g: pop input g and push its word into output dest in the same cycle; at most one transfer per cycle.
  - The rr pointer becomes (g+1) mod N at the edge. With no grant, the pointer holds.
- Latency:
  - A word pushed at edge k becomes visible in the input FIFO after edge k.
  - It can be transferred at edge k+1, so the output FIFO shows not-empty after edge k+1 (2 cycles minimum).
- Simultaneous events: a consumer pop on an output in the same cycle as a switch push to that output is legal; count is unchanged.
- Counters: counter[j] increments on each successful pop of output j (pop & !empty) and wraps at 2^CNT_W.
- Counter read:
  - When req = 1 and idle = 1 at edge k: valid_contador = 1 and contador_out = counter[idx] after edge k.
  - The value is the count before any pop at edge k.
  - Otherwise valid_contador = 0 and contador_out holds its value.
- idle is registered; it reflects the FIFO state of the previous edge.

Decomposition:
- Shared package/include: DEST_W/PTR_W derivation, default thresholds, and reset constants for the counter and pointer.
- Sub-module fifo_sa (show-ahead FIFO with thresholds and an overflow flag), instantiated 2*N times.
- Arbiter, routing and counters live in conmutador_nxn.

Test Plan (N=4, DATA_W=10, DEPTH=8, alto=6, bajo=1):
- Reset check: after reset, empty_fifos = 8'hFF, idle = 1, data_out = 0; push 10'h2A5 (dest 2) on input 0 → empty_fifos[6] clears 2 cycles later and data_out ch2 = 10'h2A5.
- Fairness: all 4 inputs hold 3 words each, destinations spread, no pops → grants rotate 0,1,2,3,0,... with no input starved.
- Backpressure: fill output 1 to 6 words (no pop) → no further grants to dest 1; other destinations still flow; popping one word from output 1 resumes transfers within 1 cycle.
- Overflow: 9 pushes into input 3 while its dest output is almost_full → overflow_err[3] = 1 and stays 1; stored words are 8.
- Counter read: pop 5 words from output 0 → idle, req = 1, idx = 0 → next cycle valid_contador = 1, contador_out = 5; req with idle = 0 → valid_contador = 0.
- Mid-operation reset: assert reset during transfers → all outputs return to reset values immediately (asynchronously) and the counters read 0.
